// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_OFF_W = $clog2(WORD_BYTES);
  localparam int unsigned CNT_W      = 4;

  // True when addr is word aligned and no bit above the word index is set.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned idx_w);
    logic ok;
    ok = (addr[BYTE_OFF_W-1:0] == '0);
    for (int unsigned i = 0; i < 32; i++) begin
      if ((i >= idx_w + BYTE_OFF_W) && addr[i]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM: synchronous write, registered read port with a resettable output.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Storage contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the MEM-stage load/store interface: one request at a time,
// completed LATENCY cycles after acceptance with a one-cycle ack pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;

  logic             enter_done;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_ok;
  logic             mem_we;
  logic             mem_re;
  logic [IDX_W-1:0] mem_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    enter_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = CNT_INIT;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d    = DONE;
            enter_done = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // With LATENCY == 1 the access happens on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-captured fields.
    acc_we    = (state_q == IDLE) ? we_i    : we_q;
    acc_addr  = (state_q == IDLE) ? addr_i  : addr_q;
    acc_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
    acc_ok    = addr_in_range(acc_addr, IDX_W);

    if (enter_done) begin
      err_d = ~acc_ok;
    end

    mem_we  = enter_done & acc_we & acc_ok & ~rst_i;
    mem_re  = enter_done & ~acc_we & acc_ok;
    mem_idx = acc_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .idx_i  (mem_idx),
    .wdata_i(acc_wdata),
    .rdata_o(rdata_o)
  );

  assign stall_o = ((state_q == IDLE) & req_i) | (state_q == BUSY);
  assign ack_o   = (state_q == DONE);
  assign err_o   = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder at LATENCY 3 and one at LATENCY 1, shared store/load fields.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst3, rst1, req3, req1, we;
  logic [31:0] addr, wdata;
  logic        stall3, ack3, err3, stall1, ack1, err1;
  logic [31:0] rdata3, rdata1;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .req_i(req3), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall3), .ack_o(ack3), .rdata_o(rdata3), .err_o(err3)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
  );

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on the selected instance; checks stall, latency, ack, err and rdata.
  task automatic xfer(input bit u1, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int lat, input logic exp_err, input logic [31:0] exp_rd,
                      input bit drop_early, input string tag);
    int k;
    int stall_hi;
    k = 0;
    stall_hi = 0;
    @(negedge clk);
    we = w; addr = a; wdata = d;
    if (u1) req1 = 1'b1; else req3 = 1'b1;
    #1 check32({tag, ".stall_req"}, 32'(u1 ? stall1 : stall3), 32'd1);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (drop_early && c == 1) begin
        req1 = 1'b0;
        req3 = 1'b0;
      end
      if ((u1 ? ack1 : ack3) === 1'b1) begin
        k = c;
        break;
      end
      if ((u1 ? stall1 : stall3) === 1'b1) stall_hi++;
    end
    check32({tag, ".lat"},      32'(k), 32'(lat));
    check32({tag, ".stall_wt"}, 32'(stall_hi), 32'(lat - 1));
    check32({tag, ".stall_ack"}, 32'(u1 ? stall1 : stall3), 32'd0);
    check32({tag, ".err"},      32'(u1 ? err1 : err3), 32'(exp_err));
    check32({tag, ".rdata"},    u1 ? rdata1 : rdata3, exp_rd);
    req1 = 1'b0;
    req3 = 1'b0;
    @(negedge clk);
    check32({tag, ".ack_off"}, 32'(u1 ? ack1 : ack3), 32'd0);
    check32({tag, ".err_off"}, 32'(u1 ? err1 : err3), 32'd0);
  endtask

  initial begin
    int acks;
    rst3 = 1'b1; rst1 = 1'b1; req3 = 1'b0; req1 = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst.stall3", 32'(stall3), 32'd0);
    check32("rst.ack3",   32'(ack3),   32'd0);
    check32("rst.err3",   32'(err3),   32'd0);
    check32("rst.rdata3", rdata3,      32'h0);
    check32("rst.stall1", 32'(stall1), 32'd0);
    check32("rst.ack1",   32'(ack1),   32'd0);
    check32("rst.rdata1", rdata1,      32'h0);
    rst3 = 1'b0; rst1 = 1'b0;

    // LATENCY 3
    xfer(0, 1'b1, 32'h20,  32'h11112222, 3, 1'b0, 32'h0,        0, "st20");
    xfer(0, 1'b1, 32'h10,  32'hDEADBEEF, 3, 1'b0, 32'h0,        0, "st10");
    xfer(0, 1'b0, 32'h10,  32'h0,        3, 1'b0, 32'hDEADBEEF, 0, "ld10");
    xfer(0, 1'b1, 32'h13,  32'hFFFFFFFF, 3, 1'b1, 32'hDEADBEEF, 0, "st13_mis");
    xfer(0, 1'b0, 32'h20,  32'h0,        3, 1'b0, 32'h11112222, 0, "ld20");
    xfer(0, 1'b0, 32'h10,  32'h0,        3, 1'b0, 32'hDEADBEEF, 0, "ld10_kept");
    xfer(0, 1'b0, 32'h400, 32'h0,        3, 1'b1, 32'hDEADBEEF, 0, "ld400_oor");

    // Reset while the counter is 1 aborts the store.
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check32("abort.stall_busy", 32'(stall3), 32'd1);
    rst3 = 1'b1; req3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    acks = 0;
    check32("abort.rdata_rst", rdata3, 32'h0);
    check32("abort.stall_rst", 32'(stall3), 32'd0);
    for (int c = 0; c < 6; c++) begin
      if (ack3 === 1'b1) acks++;
      @(negedge clk);
    end
    check32("abort.no_ack", 32'(acks), 32'd0);
    xfer(0, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h11112222, 0, "ld20_after_abort");

    // Request dropped in BUSY still completes.
    xfer(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1, "ld10_drop");
    check32("drop.stall_idle", 32'(stall3), 32'd0);

    // LATENCY 1
    xfer(1, 1'b1, 32'h0, 32'h12345678, 1, 1'b0, 32'h0,        0, "l1.st0");
    xfer(1, 1'b0, 32'h0, 32'h0,        1, 1'b0, 32'h12345678, 0, "l1.ld0");

    // Back-to-back with req held: ack, idle cycle, ack.
    @(negedge clk);
    we = 1'b0; addr = 32'h0; req1 = 1'b1;
    @(negedge clk);
    check32("b2b.ack_a",   32'(ack1),   32'd1);
    check32("b2b.rdata_a", rdata1,      32'h12345678);
    @(negedge clk);
    check32("b2b.gap_ack",   32'(ack1),   32'd0);
    check32("b2b.gap_stall", 32'(stall1), 32'd1);
    @(negedge clk);
    check32("b2b.ack_b",   32'(ack1),   32'd1);
    check32("b2b.rdata_b", rdata1,      32'h12345678);
    req1 = 1'b0;
    @(negedge clk);
    check32("b2b.ack_off", 32'(ack1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
